red_pitaya_daisy_tx_framer: RTL

Parametrised transmit framer for the daisy-chain link. It sits in the parallel clock domain, ahead of an external OSERDESE2/ODDR serializer stage. It accepts DW-bit words over a ready/valid handshake into a small FIFO and slices each word into LW-bit lane symbols, LSB slice first. Against the first-generation TX path it adds input buffering, back-pressure, a link-training mode, a frame marker, an idle/valid indication and optional per-frame parity.

---
 rtl/red_pitaya_daisy_pkg.sv | 41 ++++
 rtl/red_pitaya_daisy_tx_fifo.sv | 59 +++++
 rtl/red_pitaya_daisy_tx_framer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/red_pitaya_daisy_pkg.sv
// Shared daisy-chain link definitions: framer state encoding, slice parity
// fold and the configuration legality check used by the TX and RX sides.
package red_pitaya_daisy_pkg;

    localparam int DAISY_MAX_W  = 1024;
    localparam int DAISY_MAX_NS = 64;

    typedef enum logic [1:0] {
        ST_DATA   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_BYPASS = 2'd2
    } daisy_state_e;

    // Word must split into at least two whole lane symbols; FIFO depth a power of 2.
    function automatic bit daisy_cfg_ok(input int dw, input int lw, input int fd);
        bit ok;
        ok = (lw > 0) && (dw > 0) && (dw < DAISY_MAX_W);
        if (ok) begin
            ok = ((dw % lw) == 0) && ((dw / lw) >= 2) && ((dw / lw) <= DAISY_MAX_NS);
        end
        ok = ok && (fd >= 2) && ((fd & (fd - 1)) == 0);
        return ok;
    endfunction

    // The low lw bits of the result are the XOR of the ns lw-bit slices of w.
    function automatic logic [DAISY_MAX_W-1:0] daisy_parity_fold(
        input logic [DAISY_MAX_W-1:0] w,
        input int                     ns,
        input int                     lw
    );
        logic [DAISY_MAX_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < DAISY_MAX_NS; i++) begin
            if (i < ns) begin
                acc = acc ^ (w >> (i * lw));
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/red_pitaya_daisy_tx_fifo.sv
// Single-clock word FIFO for the daisy TX framer; first-word-fall-through read
// port, async active-low reset of the pointers only.
module red_pitaya_daisy_tx_fifo #(
    parameter int DW = 16,
    parameter int FD = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   push_i,
    input  logic [DW-1:0]          wdat_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          rdat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(FD):0]    lvl_o
);

    localparam int AW = $clog2(FD);

    logic [DW-1:0] mem_q [FD];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        lvl_o    = wr_ptr_q - rd_ptr_q;
        full_o   = (lvl_o == (AW+1)'(FD));
        empty_o  = (lvl_o == '0);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        rdat_o = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdat_i;
        end
    end

endmodule

// File: rtl/red_pitaya_daisy_tx_framer.sv
// Daisy-chain TX framer: buffers words and slices them LSB-first into lane
// symbols with training and bypass modes. Define DAISY_TX_PARITY_EN for a parity slot.
module red_pitaya_daisy_tx_framer
    import red_pitaya_daisy_pkg::*;
#(
    parameter int             DW        = 16,
    parameter int             LW        = 4,
    parameter int             FD        = 4,
    parameter logic [LW-1:0]  TRAIN_PAT = 4'h9
) (
    input  logic                 par_clk_i,
    input  logic                 par_rstn_i,
    input  logic                 sync_mode_i,
    input  logic                 train_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DW-1:0]        s_dat_i,
    output logic [LW-1:0]        lane_o,
    output logic                 lane_vld_o,
    output logic                 frame_o,
    output logic [$clog2(FD):0]  fifo_lvl_o
);

    localparam int NS = DW / LW;
`ifdef DAISY_TX_PARITY_EN
    localparam int NF = NS + 1;
`else
    localparam int NF = NS;
`endif
    localparam int SW = $clog2(NF);

    if (!daisy_cfg_ok(DW, LW, FD)) begin : g_cfg_err
        $error("red_pitaya_daisy_tx_framer: illegal DW/LW/FD combination");
    end

    daisy_state_e  state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] word_q, word_d;
    logic          act_q, act_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          vld_q, vld_d;
    logic          frame_q, frame_d;

    logic          push, pop, full, empty;
    logic [DW-1:0] rd_data;
    logic [LW-1:0] lane_sl, lane_par;

    red_pitaya_daisy_tx_fifo #(
        .DW (DW),
        .FD (FD)
    ) u_fifo (
        .clk_i   (par_clk_i),
        .rstn_i  (par_rstn_i),
        .push_i  (push),
        .wdat_i  (s_dat_i),
        .pop_i   (pop),
        .rdat_o  (rd_data),
        .full_o  (full),
        .empty_o (empty),
        .lvl_o   (fifo_lvl_o)
    );

    // FIFO is frozen in bypass; the upstream sees a permanently ready sink.
    assign push      = s_valid_i && !full && (state_q != ST_BYPASS);
    assign s_ready_o = (state_q == ST_BYPASS) || !full;

    assign lane_sl  = LW'(word_q >> (LW * int'(sel_q)));
    assign lane_par = LW'(daisy_parity_fold(DAISY_MAX_W'(word_q), NS, LW));

    always_comb begin
        sel_d   = (sel_q == SW'(NF-1)) ? '0 : sel_q + SW'(1);
        state_d = state_q;
        word_d  = word_q;
        act_d   = act_q;
        lane_d  = '0;
        vld_d   = 1'b0;
        frame_d = 1'b0;
        pop     = 1'b0;

        // Mode requests only land on frame boundaries so no frame is cut short.
        if (sel_q == SW'(NF-1)) begin
            if (sync_mode_i) begin
                state_d = ST_BYPASS;
            end else if (train_i) begin
                state_d = ST_TRAIN;
            end else begin
                state_d = ST_DATA;
            end
        end

        case (state_q)
            ST_BYPASS: begin
                lane_d = s_dat_i[LW-1:0];
                vld_d  = s_valid_i;
            end
            ST_TRAIN: begin
                lane_d  = TRAIN_PAT;
                frame_d = (sel_q == '0);
            end
            default: begin
                if (sel_q == '0) begin
                    act_d = !empty;
                    if (!empty) begin
                        pop     = 1'b1;
                        word_d  = rd_data;
                        lane_d  = rd_data[LW-1:0];
                        vld_d   = 1'b1;
                        frame_d = 1'b1;
                    end
                end else if (act_q) begin
                    lane_d = (int'(sel_q) < NS) ? lane_sl : lane_par;
                    vld_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
        if (!par_rstn_i) begin
            state_q <= ST_DATA;
            sel_q   <= '0;
            word_q  <= '0;
            act_q   <= 1'b0;
            lane_q  <= '0;
            vld_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            act_q   <= act_d;
            lane_q  <= lane_d;
            vld_q   <= vld_d;
            frame_q <= frame_d;
        end
    end

    assign lane_o     = lane_q;
    assign lane_vld_o = vld_q;
    assign frame_o    = frame_q;

endmodule
